// File: rtl/gz_capture_gate.sv
// gz_capture_gate: triggered ADC stream capture gate with pretrigger delay line.
// Emits PRE_DEPTH pre-trigger beats plus POST_BEATS beats, then holds off.
module gz_capture_gate #(
  parameter int DATA_WIDTH = 128,
  parameter int PRE_DEPTH  = 64,
  parameter int POST_BEATS = 448,
  parameter int HOLDOFF    = 1024
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  arm_i,
  input  logic                  auto_rearm_i,
  input  logic                  trig_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  armed_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int TOTAL = PRE_DEPTH + POST_BEATS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int HW    = $clog2(HOLDOFF + 1);
  localparam int AW    = $clog2(PRE_DEPTH);

  localparam logic [CW-1:0] FILL_LAST = CW'(PRE_DEPTH - 1);
  localparam logic [CW-1:0] LAST_K    = CW'(TOTAL - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FILL    = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  logic [2:0]            state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [HW-1:0]         hcnt, hcnt_n;
  logic [AW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] line_q [PRE_DEPTH];
  logic [DATA_WIDTH-1:0] d_old;
  logic                  beat;
  logic                  wr_en;
  logic                  emit;
  logic                  last;
  logic                  arm_clr;

  assign s_axis_tready = 1'b1;
  assign beat          = s_axis_tvalid;
  assign wr_en         = beat && (state != ST_IDLE);
  // read-before-write: slot still holds the beat PRE_DEPTH beats back
  assign d_old         = line_q[wr_ptr];

  assign armed_o = (state == ST_ARMED);
  assign busy_o  = (state == ST_FILL) ||
                   (state == ST_CAPTURE) ||
                   (state == ST_HOLDOFF);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    emit    = 1'b0;
    last    = 1'b0;
    arm_clr = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arm_i) begin
          state_n = ST_FILL;
          cnt_n   = '0;
          arm_clr = 1'b1;
        end
      end
      ST_FILL: begin
        if (beat) begin
          if (cnt == FILL_LAST) begin
            state_n = ST_ARMED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ST_ARMED: begin
        if (beat && trig_i) begin
          emit    = 1'b1;
          state_n = ST_CAPTURE;
          cnt_n   = CW'(1);
        end
      end
      ST_CAPTURE: begin
        if (beat) begin
          emit = 1'b1;
          if (cnt == LAST_K) begin
            last    = 1'b1;
            state_n = ST_HOLDOFF;
            cnt_n   = '0;
            hcnt_n  = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (hcnt == HOLD_LAST) begin
          state_n = auto_rearm_i ? ST_ARMED : ST_IDLE;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + HW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      line_q[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      wr_ptr        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done_o        <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      hcnt          <= hcnt_n;
      m_axis_tvalid <= emit;
      m_axis_tlast  <= last;
      done_o        <= last;
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (emit) begin
        m_axis_tdata <= d_old;
      end
      if (arm_clr) begin
        overflow_o <= 1'b0;
      end else if (m_axis_tvalid && !m_axis_tready) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gz_capture_gate.sv
// tb_gz_capture_gate: directed checks of gz_capture_gate
// with PRE_DEPTH=4, POST_BEATS=8, HOLDOFF=16, tdata = beat number.
module tb_gz_capture_gate;

  localparam int DW = 128;

  logic          aclk = 1'b0;
  logic          arst;
  logic          arm_i;
  logic          auto_rearm_i;
  logic          trig_i;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          armed_o;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  gz_capture_gate #(
    .DATA_WIDTH(DW),
    .PRE_DEPTH (4),
    .POST_BEATS(8),
    .HOLDOFF   (16)
  ) dut (
    .aclk         (aclk),
    .arst         (arst),
    .arm_i        (arm_i),
    .auto_rearm_i (auto_rearm_i),
    .trig_i       (trig_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .armed_o      (armed_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  task automatic drive(input logic v, input int n,
                       input logic a, input logic t,
                       input logic r);
    s_axis_tvalid = v;
    s_axis_tdata  = DW'(n);
    arm_i         = a;
    trig_i        = t;
    m_axis_tready = r;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk1(input string tag, input int n,
                      input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0b expected=%0b",
             tag, n, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input int n,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h",
             tag, n, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int n,
                         input logic ev, input int ed,
                         input logic el);
    chk1({tag, "_tvalid"}, n, m_axis_tvalid, ev);
    chk1({tag, "_tlast"}, n, m_axis_tlast, el);
    chk1({tag, "_done"}, n, done_o, el);
    if (ev) chkd({tag, "_tdata"}, n, m_axis_tdata, DW'(ed));
  endtask

  task automatic chk_zero(input string tag, input int n);
    chk1({tag, "_tvalid"}, n, m_axis_tvalid, 1'b0);
    chk1({tag, "_tlast"}, n, m_axis_tlast, 1'b0);
    chk1({tag, "_done"}, n, done_o, 1'b0);
    chk1({tag, "_armed"}, n, armed_o, 1'b0);
    chk1({tag, "_busy"}, n, busy_o, 1'b0);
    chk1({tag, "_ovf"}, n, overflow_o, 1'b0);
    chkd({tag, "_tdata"}, n, m_axis_tdata, '0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    arst = 1'b0;
  endtask

  initial begin
    logic v;
    int   n;

    arst          = 1'b1;
    auto_rearm_i  = 1'b0;
    arm_i         = 1'b0;
    trig_i        = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk_zero("rst", 0);
    chk1("rst_sready", 0, s_axis_tready, 1'b1);
    arst = 1'b0;

    // continuous beats, arm n=0, trig n=20
    for (int i = 0; i <= 50; i++) begin
      drive(1'b1, i, i == 0, i == 20, 1'b1);
      chk_out("A", i, i >= 20 && i <= 31, i - 4, i == 31);
      chk1("A_armed", i, armed_o, i >= 4 && i <= 19);
      chk1("A_busy", i, busy_o,
           i <= 3 || (i >= 20 && i <= 46));
    end

    // trigger during fill is ignored
    do_reset();
    for (int i = 0; i <= 24; i++) begin
      drive(1'b1, i, i == 0, i == 2 || i == 10, 1'b1);
      chk_out("B", i, i >= 10 && i <= 21, i - 4, i == 21);
    end

    // valid every other cycle, holdoff counts cycles
    do_reset();
    for (int c = 0; c <= 80; c++) begin
      v = (c % 2 == 0);
      n = c / 2;
      drive(v, n, c == 0, c == 40, 1'b1);
      chk_out("C", c, v && n >= 20 && n <= 31, n - 4,
              v && n == 31);
      if (c >= 60) chk1("C_busy", c, busy_o, c <= 77);
    end

    // one dropped beat sets sticky overflow
    do_reset();
    for (int i = 0; i <= 51; i++) begin
      drive(1'b1, i, i == 0 || i == 50, i == 20, i != 23);
      if (i <= 40)
        chk_out("D", i, i >= 20 && i <= 31, i - 4, i == 31);
      chk1("D_ovf", i, overflow_o, i >= 23 && i < 50);
    end

    // auto rearm with trigger held high
    do_reset();
    auto_rearm_i = 1'b1;
    for (int i = 0; i <= 60; i++) begin
      drive(1'b1, i, i == 0, i >= 20, 1'b1);
      chk_out("E", i,
              (i >= 20 && i <= 31) || (i >= 48 && i <= 59),
              i - 4, i == 31 || i == 59);
      chk1("E_armed", i, armed_o,
           (i >= 4 && i <= 19) || i == 47);
    end
    auto_rearm_i = 1'b0;

    // reset in the middle of a capture window
    do_reset();
    for (int i = 0; i <= 25; i++) begin
      drive(1'b1, i, i == 0, i == 20, 1'b1);
      chk_out("F", i, i >= 20 && i <= 31, i - 4, i == 31);
    end
    arst = 1'b1;
    drive(1'b1, 26, 1'b0, 1'b0, 1'b1);
    arst = 1'b0;
    chk_zero("F_rst", 26);
    for (int i = 27; i <= 29; i++) begin
      drive(1'b1, i, 1'b0, 1'b1, 1'b1);
      chk_zero("F_idle", i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
